// File: rtl/mpsoc_noc_pkg.sv
// ============================================================================
// Module   : mpsoc_noc_pkg
// Brief    : Shared types and the round-robin pick helper for the NoC VC scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mpsoc_noc_pkg;

    localparam int c_max_ch = 32;
    localparam int c_idx_w  = 5;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    // Index of the first set bit of req at or after ptr, wrapping modulo n (n <= c_max_ch).
    function automatic logic [c_idx_w-1:0] rr_pick(
        input logic [c_max_ch-1:0] req,
        input logic [c_idx_w-1:0]  ptr,
        input logic [c_idx_w:0]    n
    );
        logic [c_idx_w:0] idx;
        logic             found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < c_max_ch; i++) begin
            idx = {1'b0, ptr} + (c_idx_w+1)'(i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((i < int'(n)) && !found && req[idx[c_idx_w-1:0]]) begin
                rr_pick = idx[c_idx_w-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/mpsoc_noc_vchannel_credit.sv
// ============================================================================
// Module   : mpsoc_noc_vchannel_credit
// Brief    : Per-VC downstream credit counter with saturation and sticky overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mpsoc_noc_vchannel_credit #(
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          nz,
    output logic          overflow
);

    localparam logic [CW-1:0] c_full = CW'(CREDITS);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_nz;
    logic          r_ovf;
    logic          w_ovf_nxt;

    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        if (dec && !inc) begin
            w_count_nxt = r_count - 1'b1;
        end else if (inc && !dec) begin
            // A return into a full counter is a downstream protocol error; saturate.
            if (r_count == c_full) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= c_full;
            r_nz    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_nz    <= (w_count_nxt != '0);
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign count    = r_count;
    assign nz       = r_nz;
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: rtl/mpsoc_noc_vchannel_sched.sv
// ============================================================================
// Module   : mpsoc_noc_vchannel_sched
// Brief    : Credit-based, packet-locked round-robin VC scheduler for a router output mux.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mpsoc_noc_vchannel_sched #(
    parameter int CHANNELS = 7,
    parameter int CREDITS  = 4,
    parameter int CW       = $clog2(CREDITS+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in_valid,
    input  logic [CHANNELS-1:0] in_last,
    input  logic [CHANNELS-1:0] credit_ret,
    output logic [CHANNELS-1:0] select,
    output logic [CHANNELS-1:0] in_ready,
    output logic                xfer,
    output logic [CHANNELS-1:0] credit_nz,
    output logic                credit_err
);

    import mpsoc_noc_pkg::*;

    localparam logic [CHANNELS-1:0] c_one  = CHANNELS'(1);
    localparam logic [c_idx_w-1:0]  c_last = c_idx_w'(CHANNELS-1);
    localparam logic [c_idx_w:0]    c_n    = (c_idx_w+1)'(CHANNELS);

    sched_state_t               r_state;
    sched_state_t               w_state_nxt;
    logic [CHANNELS-1:0]        r_sel;
    logic [CHANNELS-1:0]        w_sel_nxt;
    logic [c_idx_w-1:0]         r_ptr;
    logic [c_idx_w-1:0]         w_ptr_nxt;
    logic [c_idx_w-1:0]         r_cur;
    logic [c_idx_w-1:0]         w_cur_nxt;
    logic [c_idx_w-1:0]         w_pick;
    logic [c_max_ch-1:0]        w_req;
    logic [CHANNELS-1:0]        w_elig;
    logic [CHANNELS-1:0]        w_xfer_vec;
    logic [CHANNELS-1:0]        w_ovf;
    logic [CHANNELS-1:0][CW-1:0] w_count;
    logic                       w_last_xfer;

    assign w_elig      = in_valid & credit_nz;
    assign w_xfer_vec  = r_sel & in_valid & credit_nz;
    assign w_last_xfer = |(w_xfer_vec & in_last);

    always_comb begin
        w_req                 = '0;
        w_req[CHANNELS-1:0]   = w_elig;
    end

    assign w_pick = rr_pick(w_req, r_ptr, c_n);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cur_nxt   = r_cur;
        case (r_state)
            IDLE: begin
                w_sel_nxt = '0;
                if (|w_elig) begin
                    w_state_nxt = LOCKED;
                    w_sel_nxt   = c_one << w_pick;
                    w_cur_nxt   = w_pick;
                end
            end
            LOCKED: begin
                // Wormhole: only the tail flit releases the lock.
                if (w_last_xfer) begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = '0;
                    w_ptr_nxt   = (r_cur == c_last) ? '0 : r_cur + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cur   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cur   <= w_cur_nxt;
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_credit
            mpsoc_noc_vchannel_credit #(
                .CREDITS (CREDITS),
                .CW      (CW)
            ) u_credit (
                .clk      (clk),
                .rst      (rst),
                .dec      (w_xfer_vec[c]),
                .inc      (credit_ret[c]),
                .count    (w_count[c]),
                .nz       (credit_nz[c]),
                .overflow (w_ovf[c])
            );

            a_count_bound : assert property (@(posedge clk) disable iff (!rst)
                w_count[c] <= CW'(CREDITS));
        end
    endgenerate

    a_sel_onehot : assert property (@(posedge clk) $onehot0(r_sel));

    assign select     = r_sel;
    assign in_ready   = r_sel & credit_nz;
    assign xfer       = |w_xfer_vec;
    assign credit_err = |w_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mpsoc_noc_vchannel_sched.sv
// ============================================================================
// Module   : tb_mpsoc_noc_vchannel_sched
// Brief    : Directed self-checking bench for the VC scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mpsoc_noc_vchannel_sched;

    localparam int CH = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] in_valid;
    logic [CH-1:0] in_last;
    logic [CH-1:0] credit_ret;
    logic [CH-1:0] select;
    logic [CH-1:0] in_ready;
    logic          xfer;
    logic [CH-1:0] credit_nz;
    logic          credit_err;

    int checks = 0;
    int errors = 0;

    mpsoc_noc_vchannel_sched #(
        .CHANNELS (CH),
        .CREDITS  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .credit_ret (credit_ret),
        .select     (select),
        .in_ready   (in_ready),
        .xfer       (xfer),
        .credit_nz  (credit_nz),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst        = 1'b0;
        in_valid   = '0;
        in_last    = '0;
        credit_ret = '0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    logic [CH-1:0] alt_exp [7];

    initial begin
        alt_exp = '{7'h01, 7'h00, 7'h04, 7'h00, 7'h01, 7'h00, 7'h04};

        // Reset state and a 3-flit packet on VC0
        do_reset;
        chk("rst_select", select, 0);
        chk("rst_nz", credit_nz, 7'h7f);
        chk("rst_err", credit_err, 0);
        chk("rst_cnt0", dut.w_count[0], 4);
        in_valid = 7'b0000001;
        #1;
        chk("req_xfer", xfer, 0);
        chk("req_select", select, 0);
        tick;
        chk("p1_select", select, 7'h01);
        chk("p1_xfer1", xfer, 1);
        chk("p1_ready", in_ready, 7'h01);
        tick;
        chk("p1_xfer2", xfer, 1);
        chk("p1_cnt_a", dut.w_count[0], 3);
        tick;
        in_last = 7'b0000001;
        #1;
        chk("p1_xfer3", xfer, 1);
        chk("p1_cnt_b", dut.w_count[0], 2);
        tick;
        in_valid = '0;
        in_last  = '0;
        #1;
        chk("p1_release", select, 0);
        chk("p1_cnt_end", dut.w_count[0], 1);
        chk("p1_nz0", credit_nz[0], 1);

        // Single-flit packets on VC0/VC2 alternate with a bubble between grants
        do_reset;
        in_valid = 7'b0000101;
        in_last  = 7'b0000101;
        #1;
        chk("alt_idle", select, 0);
        for (int i = 0; i < 7; i++) begin
            tick;
            chk($sformatf("alt_sel%0d", i), select, alt_exp[i]);
            chk($sformatf("alt_xfer%0d", i), xfer, (alt_exp[i] != 0) ? 1 : 0);
        end
        tick;
        in_valid = '0;
        in_last  = '0;
        #1;
        chk("alt_end", select, 0);
        chk("alt_cnt0", dut.w_count[0], 2);
        chk("alt_cnt2", dut.w_count[2], 2);

        // Simultaneous transfer and credit return on VC0 at count 2
        in_valid = 7'b0000001;
        tick;
        chk("sim_select", select, 7'h01);
        in_last    = 7'b0000001;
        credit_ret = 7'b0000001;
        #1;
        chk("sim_xfer", xfer, 1);
        tick;
        credit_ret = '0;
        in_valid   = '0;
        in_last    = '0;
        #1;
        chk("sim_cnt0", dut.w_count[0], 2);
        chk("sim_nz0", credit_nz[0], 1);
        chk("sim_release", select, 0);

        // VC1 6-flit packet stalls on credits; VC3 must wait
        do_reset;
        in_valid = 7'b0001010;
        tick;
        chk("vc1_select", select, 7'h02);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("vc1_xfer%0d", i), xfer, 1);
            chk($sformatf("vc1_hold%0d", i), select, 7'h02);
            tick;
        end
        chk("vc1_stall_xfer", xfer, 0);
        chk("vc1_stall_sel", select, 7'h02);
        chk("vc1_stall_rdy", in_ready, 0);
        chk("vc1_stall_nz", credit_nz[1], 0);
        tick;
        chk("vc1_wh_sel", select, 7'h02);
        chk("vc1_wh_xfer", xfer, 0);
        credit_ret = 7'b0000010;
        tick;
        credit_ret = '0;
        #1;
        chk("vc1_ret1_xfer", xfer, 1);
        chk("vc1_ret1_sel", select, 7'h02);
        tick;
        chk("vc1_ret1_stop", xfer, 0);
        chk("vc1_ret1_hold", select, 7'h02);
        credit_ret = 7'b0000010;
        in_last    = 7'b0000010;
        tick;
        credit_ret = '0;
        #1;
        chk("vc1_ret2_xfer", xfer, 1);
        tick;
        in_valid = '0;
        in_last  = '0;
        #1;
        chk("vc1_release", select, 0);
        chk("vc1_cnt", dut.w_count[1], 0);

        // Credit overflow on idle VC4 is sticky
        credit_ret = 7'b0010000;
        tick;
        credit_ret = '0;
        #1;
        chk("ovf_cnt4", dut.w_count[4], 4);
        chk("ovf_err", credit_err, 1);
        tick;
        tick;
        chk("ovf_sticky", credit_err, 1);

        // Reset mid-packet on VC5, then VC0 has priority
        in_valid = 7'b0100000;
        tick;
        chk("vc5_select", select, 7'h20);
        tick;
        chk("vc5_cnt", dut.w_count[5], 3);
        rst = 1'b0;
        tick;
        rst      = 1'b1;
        in_valid = 7'b0100001;
        in_last  = 7'b0000001;
        #1;
        chk("mid_rst_sel", select, 0);
        chk("mid_rst_err", credit_err, 0);
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("mid_rst_cnt%0d", c), dut.w_count[c], 4);
        end
        tick;
        chk("mid_rst_prio", select, 7'h01);
        in_valid = '0;
        in_last  = '0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
